dispense_scheduler: RTL and testbench
=====================================

// Module: dispense_scheduler
// PURPOSE
//  Times and sequences food dispensing from the two-digit BCD interval held by memoria.
//  Counts the interval down in BCD, raises a level request to the motor driver, waits
//  for its done pulse, reloads and repeats. Sits between memoria and the motor/display path.
//  Remaining time is exported in BCD for the 7-segment display.
// PARAMETERS
//  CLK_HZ          50_000_000  clk cycles per second tick
//  TICKS_PER_UNIT  60          second ticks per interval unit (unit = 1 min)
//  DONE_TIMEOUT    10          seconds allowed between motor_req rise and motor_done
// PORTS
//  clk         in   1  system clock, all logic on rising edge
//  rst_n       in   1  reset, asynchronous, active-low
//  enable      in   1  memoria config locked; high = run schedule, low = halt
//  unitsR      in   4  interval units digit, BCD
//  decadesR    in   4  interval decades digit, BCD
//  motor_done  in   1  one-cycle pulse from motor driver, dispense complete
//  feed_now    in   1  manual feed strobe (present only with MANUAL_FEED_EN)
//  motor_req   out  1  dispense request, level, held until motor_done or abort
//  remU        out  4  remaining units, BCD
//  remD        out  4  remaining decades, BCD
//  busy        out  1  high in any state except IDLE
//  fault       out  1  sticky motor timeout flag
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; motor_req=0, remU=remD=0, busy=0, fault=0, prescalers=0.
//  Timebase: sec_tick every CLK_HZ cycles; unit_tick every TICKS_PER_UNIT sec_ticks.
//  States: IDLE, LOAD, COUNT, WAIT_DONE.
//  IDLE: enable=1 -> LOAD. remU/remD held 0.
//  LOAD (1 cycle): capture decadesR:unitsR; digits >9 clamp to 9; clear prescalers.
//   Captured 00 -> IDLE (no dispense, busy low next cycle); else -> COUNT.
//  COUNT: each unit_tick decrements BCD: units borrow from decades (10->09, 01->00).
//   Cycle the value becomes 00 -> WAIT_DONE; motor_req=1 on the next edge (latency 1).
//  WAIT_DONE: motor_req held 1; sec counter runs from 0.
//   motor_done=1 -> motor_req=0 and LOAD next edge (picks up current unitsR/decadesR).
//   DONE_TIMEOUT sec_ticks without motor_done -> fault=1, motor_req=0, IDLE.
//  motor_done outside WAIT_DONE: ignored.
//  enable=0 in any state: next edge IDLE, motor_req=0, remU/remD=0, prescalers cleared.
//   fault cleared on enable 1->0; fault=1 blocks IDLE->LOAD until cleared.
//  Simultaneous motor_done and timeout expiry: done wins, no fault.
//  Simultaneous enable fall and motor_done: abort wins (IDLE).
//  Config changes during COUNT take effect only at next LOAD.
// CONFIGURATION
//  MANUAL_FEED_EN defined: feed_now port present; feed_now=1 in COUNT -> WAIT_DONE
//   next edge (motor_req rises), countdown then reloads as normal; ignored in other states.
//  MANUAL_FEED_EN undefined: no feed_now port; dispense only on countdown expiry.
// STRUCTURE
//  Shared package dispense_pkg: state encoding, BCD_MAX=4'd9, bcd_dec function
//   (two-digit decrement with borrow).
//  Sub-module tick_prescaler: parameterised modulo counter with clear, emits one-cycle
//   tick; instantiated twice (sec_tick, unit_tick) plus a timeout counter in scheduler.
// TESTING (CLK_HZ=4, TICKS_PER_UNIT=2, DONE_TIMEOUT=3 -> 8 cycles/unit)
//  1 Reset: rst_n low mid-COUNT between edges -> all outputs 0 immediately, state IDLE.
//  2 Interval 1,2, enable=1: remD:remU 12->11->10->09..->00 every 8 cycles;
//    motor_req rises 1 cycle after 00; motor_done pulse -> motor_req=0, remaining reloads 12.
//  3 Interval 0,0, enable=1 -> LOAD then IDLE, motor_req never rises; digit 0xC loads as 9.
//  4 Timeout: no motor_done for 12 cycles after motor_req -> fault=1, motor_req=0, IDLE;
//    enable 1->0 clears fault; late motor_done ignored.
//  5 Abort: enable=0 in WAIT_DONE -> motor_req=0, rem=00 next edge; done same cycle ignored.
//  6 MANUAL_FEED_EN: feed_now at rem=07 -> motor_req next cycle, done -> reload interval.

Source files
------------

// File: rtl/dispense_pkg.sv
// Shared types and helpers for the dispense scheduler:
// FSM state encoding, two-digit BCD value, BCD decrement and clamp.
package dispense_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COUNT,
    WAIT_DONE
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef struct packed {
    logic [3:0] d;
    logic [3:0] u;
  } bcd2_t;

  // Two-digit decrement; units borrow from decades.
  function automatic bcd2_t bcd_dec(input bcd2_t v);
    bcd2_t r;
    if (v.u == 4'd0) begin
      r.u = BCD_MAX;
      r.d = v.d - 4'd1;
    end else begin
      r.u = v.u - 4'd1;
      r.d = v.d;
    end
    return r;
  endfunction

  // Non-BCD digits saturate to 9.
  function automatic logic [3:0] bcd_clamp(
    input logic [3:0] x
  );
    return (x > BCD_MAX) ? BCD_MAX : x;
  endfunction

endpackage

// File: rtl/dispense_scheduler_tick_prescaler.sv
// Modulo-MOD counter advancing on en, cleared by clr.
// Ports: clk, rst_n, clr, en in; tick out (one cycle at count MOD-1).
module tick_prescaler #(
  parameter int MOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (MOD > 1) ? $clog2(MOD) : 1;
  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] cnt;

  // Suppressed while clearing so a stale count never leaks a tick.
  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/dispense_scheduler.sv
// Counts the BCD interval down, requests a dispense, waits for done, reloads.
// Ports: clk, rst_n, enable, unitsR, decadesR, motor_done, [feed_now] in;
//   motor_req, remU, remD, busy, fault out. MANUAL_FEED_EN adds feed_now.
module dispense_scheduler
  import dispense_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int TICKS_PER_UNIT = 60,
  parameter int DONE_TIMEOUT   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] unitsR,
  input  logic [3:0] decadesR,
  input  logic       motor_done,
`ifdef MANUAL_FEED_EN
  input  logic       feed_now,
`endif
  output logic       motor_req,
  output logic [3:0] remU,
  output logic [3:0] remD,
  output logic       busy,
  output logic       fault
);

  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST =
    TW'(DONE_TIMEOUT - 1);

  state_t  state, nstate;
  bcd2_t   rem, rem_d;
  logic    req_d, fault_d;
  logic    clr;
  logic    sec_tick, unit_tick;
  logic    to_exp;
  logic    feed;
  logic [TW-1:0] to_cnt;

`ifdef MANUAL_FEED_EN
  assign feed = feed_now;
`else
  assign feed = 1'b0;
`endif

  tick_prescaler #(
    .MOD (CLK_HZ)
  ) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (1'b1),
    .tick  (sec_tick)
  );

  tick_prescaler #(
    .MOD (TICKS_PER_UNIT)
  ) u_unit (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .en    (sec_tick),
    .tick  (unit_tick)
  );

  // Seconds since motor_req rose.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (clr || state != WAIT_DONE) begin
      to_cnt <= '0;
    end else if (sec_tick) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  assign to_exp = (state == WAIT_DONE) &&
                  sec_tick && (to_cnt == TO_LAST);

  always_comb begin
    nstate  = state;
    rem_d   = rem;
    req_d   = motor_req;
    fault_d = fault;
    clr     = 1'b0;
    if (!enable) begin
      // Abort outranks everything, including done.
      nstate  = IDLE;
      rem_d   = '0;
      req_d   = 1'b0;
      fault_d = 1'b0;
      clr     = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          rem_d = '0;
          if (!fault) nstate = LOAD;
        end
        LOAD: begin
          clr     = 1'b1;
          rem_d.d = bcd_clamp(decadesR);
          rem_d.u = bcd_clamp(unitsR);
          nstate  = (rem_d == '0) ? IDLE : COUNT;
        end
        COUNT: begin
          if (unit_tick) rem_d = bcd_dec(rem);
          if (rem_d == '0 || feed) nstate = WAIT_DONE;
        end
        WAIT_DONE: begin
          // Timebase restarts on the cycle req rises.
          clr = !motor_req;
          if (motor_done) begin
            req_d  = 1'b0;
            nstate = LOAD;
          end else if (to_exp) begin
            req_d   = 1'b0;
            fault_d = 1'b1;
            nstate  = IDLE;
          end else begin
            req_d = 1'b1;
          end
        end
        default: begin
          nstate = IDLE;
          req_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem       <= '0;
      motor_req <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= nstate;
      rem       <= rem_d;
      motor_req <= req_d;
      fault     <= fault_d;
    end
  end

  assign busy = (state != IDLE);
  assign remU = rem.u;
  assign remD = rem.d;

endmodule

// File: tb/tb_dispense_scheduler.sv
// Scoreboard bench for dispense_scheduler: expected remaining values
// are queued with stimulus and popped as the display value changes.
module tb_dispense_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic enable = 1'b0;
  logic motor_done = 1'b0;
  logic [3:0] unitsR = 4'd0;
  logic [3:0] decadesR = 4'd0;
`ifdef MANUAL_FEED_EN
  logic feed_now = 1'b0;
`endif
  logic motor_req, busy, fault;
  logic [3:0] remU, remD;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0, tr;
  logic seen;

  logic [7:0] sb[$];
  logic sb_on = 1'b0;
  logic [7:0] prev = 8'h00;

  dispense_scheduler #(
    .CLK_HZ         (4),
    .TICKS_PER_UNIT (2),
    .DONE_TIMEOUT   (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .unitsR     (unitsR),
    .decadesR   (decadesR),
    .motor_done (motor_done),
`ifdef MANUAL_FEED_EN
    .feed_now   (feed_now),
`endif
    .motor_req  (motor_req),
    .remU       (remU),
    .remD       (remD),
    .busy       (busy),
    .fault      (fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int i);
    return {4'(i / 10), 4'(i % 10)};
  endfunction

  function automatic logic [7:0] sample(input int sel);
    case (sel)
      0: return {remD, remU};
      1: return {7'd0, motor_req};
      default: return {7'd0, fault};
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_on(input string tag, input int sel,
                         input logic [7:0] v,
                         input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (sample(sel) == v) break;
    end
    chk(tag, {24'd0, sample(sel)}, {24'd0, v});
  endtask

  task automatic pulse_done();
    motor_done = 1'b1;
    step(1);
    motor_done = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [7:0] cur;
    cur = {remD, remU};
    if (sb_on && cur != prev) begin
      if (sb.size() == 0)
        chk("sb_extra", {24'd0, cur}, 32'h100);
      else
        chk("sb_rem", {24'd0, cur},
            {24'd0, sb.pop_front()});
    end
    prev = cur;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench did not finish");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req", {31'd0, motor_req}, 0);
    chk("rst_rem", {24'd0, remD, remU}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_fault", {31'd0, fault}, 0);
    @(negedge clk) rst_n = 1'b1;
    step(1);

    // Interval 12: full countdown, dispense, reload.
    decadesR = 4'd1;
    unitsR = 4'd2;
    for (int i = 12; i >= 0; i--) sb.push_back(to_bcd(i));
    sb_on = 1'b1;
    enable = 1'b1;
    wait_on("t2_load", 0, 8'h12, 5);
    t0 = cyc;
    wait_on("t2_11", 0, 8'h11, 12);
    chk("t2_gap", cyc - t0, 8);
    wait_on("t2_00", 0, 8'h00, 100);
    chk("t2_total", cyc - t0, 96);
    chk("t2_req_lat0", {31'd0, motor_req}, 0);
    chk("t2_busy", {31'd0, busy}, 1);
    step(1);
    chk("t2_req_lat1", {31'd0, motor_req}, 1);
    step(3);
    chk("t2_req_hold", {31'd0, motor_req}, 1);
    sb.push_back(8'h12);
    pulse_done();
    chk("t2_req_drop", {31'd0, motor_req}, 0);
    chk("t2_load_busy", {31'd0, busy}, 1);
    step(1);
    chk("t2_reload", {24'd0, remD, remU}, 32'h12);

    // Asynchronous reset mid-count, between edges.
    step(3);
    #2;
    sb_on = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t1_req", {31'd0, motor_req}, 0);
    chk("t1_rem", {24'd0, remD, remU}, 0);
    chk("t1_busy", {31'd0, busy}, 0);
    chk("t1_fault", {31'd0, fault}, 0);
    enable = 1'b0;
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    step(1);
    chk("t1_idle", {31'd0, busy}, 0);

    // Interval 00: load then idle, never dispenses.
    decadesR = 4'd0;
    unitsR = 4'd0;
    sb_on = 1'b1;
    enable = 1'b1;
    step(1);
    chk("t3_load", {31'd0, busy}, 1);
    step(1);
    chk("t3_idle", {31'd0, busy}, 0);
    chk("t3_rem", {24'd0, remD, remU}, 0);
    seen = 1'b0;
    repeat (10) begin
      step(1);
      seen = seen | motor_req;
    end
    chk("t3_noreq", {31'd0, seen}, 0);
    // Non-BCD digits clamp to 9.
    sb.push_back(8'h09);
    unitsR = 4'hC;
    wait_on("t3_clampu", 0, 8'h09, 5);
    sb.push_back(8'h00);
    enable = 1'b0;
    step(1);
    chk("t3_abort", {31'd0, busy}, 0);
    sb.push_back(8'h93);
    decadesR = 4'hF;
    unitsR = 4'd3;
    enable = 1'b1;
    wait_on("t3_clampd", 0, 8'h93, 5);
    sb.push_back(8'h00);
    enable = 1'b0;
    step(2);

    // Timeout with no motor_done.
    decadesR = 4'd0;
    unitsR = 4'd1;
    sb.push_back(8'h01);
    sb.push_back(8'h00);
    enable = 1'b1;
    wait_on("t4_req", 1, 8'h01, 20);
    tr = cyc;
    wait_on("t4_fault", 2, 8'h01, 20);
    chk("t4_to_cyc", cyc - tr, 12);
    chk("t4_req0", {31'd0, motor_req}, 0);
    chk("t4_idle", {31'd0, busy}, 0);
    step(4);
    chk("t4_blocked", {31'd0, busy}, 0);
    pulse_done();
    step(1);
    chk("t4_late_flt", {31'd0, fault}, 1);
    chk("t4_late_req", {31'd0, motor_req}, 0);
    chk("t4_late_bsy", {31'd0, busy}, 0);
    enable = 1'b0;
    step(1);
    chk("t4_clear", {31'd0, fault}, 0);

    // Done on the expiry cycle: done wins.
    sb.push_back(8'h01);
    sb.push_back(8'h00);
    enable = 1'b1;
    wait_on("t4b_req", 1, 8'h01, 20);
    step(11);
    sb.push_back(8'h01);
    pulse_done();
    chk("t4b_fault", {31'd0, fault}, 0);
    chk("t4b_req", {31'd0, motor_req}, 0);
    chk("t4b_busy", {31'd0, busy}, 1);
    step(2);
    sb.push_back(8'h00);
    enable = 1'b0;
    step(1);

    // Done ignored in COUNT; abort beats done.
    sb.push_back(8'h01);
    sb.push_back(8'h00);
    enable = 1'b1;
    wait_on("t5_rem", 0, 8'h01, 5);
    step(2);
    pulse_done();
    chk("t5_cnt_busy", {31'd0, busy}, 1);
    chk("t5_cnt_req", {31'd0, motor_req}, 0);
    wait_on("t5_req", 1, 8'h01, 20);
    enable = 1'b0;
    pulse_done();
    chk("t5_req0", {31'd0, motor_req}, 0);
    chk("t5_rem0", {24'd0, remD, remU}, 0);
    chk("t5_idle", {31'd0, busy}, 0);
    chk("t5_fault", {31'd0, fault}, 0);
    step(3);
    chk("t5_stay", {31'd0, busy}, 0);

`ifdef MANUAL_FEED_EN
    // Manual feed mid-count.
    decadesR = 4'd1;
    unitsR = 4'd2;
    for (int i = 12; i >= 7; i--) sb.push_back(to_bcd(i));
    enable = 1'b1;
    wait_on("t6_07", 0, 8'h07, 60);
    feed_now = 1'b1;
    step(1);
    feed_now = 1'b0;
    chk("t6_req0", {31'd0, motor_req}, 0);
    step(1);
    chk("t6_req1", {31'd0, motor_req}, 1);
    chk("t6_rem", {24'd0, remD, remU}, 32'h07);
    sb.push_back(8'h12);
    pulse_done();
    chk("t6_drop", {31'd0, motor_req}, 0);
    step(1);
    chk("t6_reload", {24'd0, remD, remU}, 32'h12);
    sb.push_back(8'h00);
    enable = 1'b0;
    step(1);
`endif

    step(2);
    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
